// File: rtl/gate_bank_bist_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : gate_bank_bist_if                                             |
// | Purpose  : Bus bundle for the gate_bank_bist N-channel gate bank.        |
// |            Carries the gate operands and mode, registered results, and   |
// |            the BIST handshake/status signals.                            |
// | Ports    : mode[2:0], a/b/y[CHANNELS-1:0], bist_start, bist_busy,        |
// |            bist_done, bist_pass, bist_fail_mask[CHANNELS-1:0]            |
// |            fault_mask[CHANNELS-1:0] only when FAULT_INJECT_EN is defined |
// | Modports : master (stimulus side), slave (gate bank side)                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface gate_bank_bist_if #(
  parameter int CHANNELS = 4
);
  logic [2:0]          mode;
  logic [CHANNELS-1:0] a;
  logic [CHANNELS-1:0] b;
  logic [CHANNELS-1:0] y;
  logic                bist_start;
  logic                bist_busy;
  logic                bist_done;
  logic                bist_pass;
  logic [CHANNELS-1:0] bist_fail_mask;
`ifdef FAULT_INJECT_EN
  logic [CHANNELS-1:0] fault_mask;

  modport master (
    output mode, a, b, bist_start, fault_mask,
    input  y, bist_busy, bist_done, bist_pass, bist_fail_mask
  );
  modport slave (
    input  mode, a, b, bist_start, fault_mask,
    output y, bist_busy, bist_done, bist_pass, bist_fail_mask
  );
`else
  modport master (
    output mode, a, b, bist_start,
    input  y, bist_busy, bist_done, bist_pass, bist_fail_mask
  );
  modport slave (
    input  mode, a, b, bist_start,
    output y, bist_busy, bist_done, bist_pass, bist_fail_mask
  );
`endif
endinterface
`default_nettype wire

// File: rtl/gate_bank_bist.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : gate_bank_bist                                                |
// | Purpose  : Registered N-channel two-input gate bank with one shared      |
// |            runtime mode (AND/OR/XOR/NAND/NOR/XNOR, 6/7 -> 0) and a       |
// |            built-in self-test that sweeps vectors 00,01,10,11 through    |
// |            every channel and reports a sticky per-channel fail mask.     |
// | Ports    : clk        - system clock, rising edge                        |
// |            rst_n      - synchronous active-low reset                     |
// |            bus        - gate_bank_bist_if.slave (mode, a, b, y, BIST)    |
// | Options  : FAULT_INJECT_EN - adds bus.fault_mask; inverts registered y   |
// |            per set bit in both normal and BIST operation.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module gate_bank_bist #(
  parameter int CHANNELS    = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  gate_bank_bist_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int              HOLD_W    = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  function automatic logic gate_fn(input logic [2:0] m, input logic ai, input logic bi);
    logic r;
    case (m)
      3'd0:    r = ai & bi;
      3'd1:    r = ai | bi;
      3'd2:    r = ai ^ bi;
      3'd3:    r = ~(ai & bi);
      3'd4:    r = ~(ai | bi);
      3'd5:    r = ~(ai ^ bi);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [1:0]          vec_q, vec_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [2:0]          bist_mode_q, bist_mode_d;
  logic [CHANNELS-1:0] y_q, y_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [CHANNELS-1:0] fail_mask_q, fail_mask_d;

  logic                in_run;
  logic [2:0]          fn_mode;
  logic                exp_bit;
  logic [CHANNELS-1:0] gate_a;
  logic [CHANNELS-1:0] gate_b;
  logic [CHANNELS-1:0] gate_y;
  logic [CHANNELS-1:0] mism;
  logic [CHANNELS-1:0] inv_mask;

  // While RUN owns the gates, all channels see the same BIST vector and the
  // mode latched at start; live a/b/mode are ignored.
  assign in_run  = (state_q == ST_RUN);
  assign fn_mode = in_run ? bist_mode_q : bus.mode;
  assign exp_bit = gate_fn(bist_mode_q, vec_q[1], vec_q[0]);

`ifdef FAULT_INJECT_EN
  assign inv_mask = bus.fault_mask;
`else
  assign inv_mask = '0;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign gate_a[i] = in_run ? vec_q[1] : bus.a[i];
    assign gate_b[i] = in_run ? vec_q[0] : bus.b[i];
    assign gate_y[i] = gate_fn(fn_mode, gate_a[i], gate_b[i]);
    assign mism[i]   = y_q[i] ^ exp_bit;
  end

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    hold_d      = hold_q;
    bist_mode_d = bist_mode_q;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    done_d      = 1'b0;
    y_d         = gate_y ^ inv_mask;
    // Status outputs lag the FSM by one edge so busy covers RUN+DONE and the
    // done pulse lands together with the final pass verdict.
    busy_d      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        // busy_q still shows the DONE cycle just after returning to IDLE;
        // a start seen while busy is visible is ignored.
        if (bus.bist_start && !busy_q) begin
          state_d     = ST_RUN;
          bist_mode_d = bus.mode;
          fail_mask_d = '0;
          pass_d      = 1'b0;
          vec_d       = 2'd0;
          hold_d      = '0;
        end
      end
      ST_RUN: begin
        // hold==0 is the settle cycle for registered y; compare on the last
        // hold cycle of each vector.
        if (hold_q == HOLD_LAST) begin
          fail_mask_d = fail_mask_q | mism;
          hold_d      = '0;
          vec_d       = 2'(vec_q + 2'd1);
          if (vec_q == 2'd3) begin
            state_d = ST_DONE;
          end
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        pass_d  = (fail_mask_q == '0);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vec_q       <= 2'd0;
      hold_q      <= '0;
      bist_mode_q <= 3'd0;
      y_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      hold_q      <= hold_d;
      bist_mode_q <= bist_mode_d;
      y_q         <= y_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  assign bus.y              = y_q;
  assign bus.bist_busy      = busy_q;
  assign bus.bist_done      = done_q;
  assign bus.bist_pass      = pass_q;
  assign bus.bist_fail_mask = fail_mask_q;

endmodule
`default_nettype wire
